// File: rtl/psg_n.sv
// psg_n: programmable sound generator with NUM_CH square-wave tone channels,
// a shared 17-bit LFSR noise source and a shared AY-style envelope, mixed into one sample.
module psg_n #(
  parameter int NUM_CH = 3,
  parameter int TONE_W = 12,
  parameter int DIV_W  = 4,
  parameter int ADDR_W = 5,
  parameter int OUT_W  = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [7:0]        in_val,
  input  logic              in_wr,
  output logic [OUT_W-1:0]  out_mix,
  output logic [3:0]        out_env
);

  localparam int A_NP    = 2 * NUM_CH;
  localparam int A_TDIS  = 2 * NUM_CH + 1;
  localparam int A_NDIS  = 2 * NUM_CH + 2;
  localparam int A_AMP   = 2 * NUM_CH + 3;
  localparam int A_EPL   = 3 * NUM_CH + 3;
  localparam int A_EPH   = 3 * NUM_CH + 4;
  localparam int A_SHAPE = 3 * NUM_CH + 5;
  localparam int SUM_W   = $clog2(15 * NUM_CH + 1);
  localparam int SCALE   = ((2 ** OUT_W) - 1) / (15 * NUM_CH);

  logic              wr_prev;
  logic              wr_stb;
  logic              shape_wr;

  logic [TONE_W-1:0] period [NUM_CH];
  logic [4:0]        noise_per;
  logic [NUM_CH-1:0] tdis;
  logic [NUM_CH-1:0] ndis;
  logic [3:0]        amp [NUM_CH];
  logic [NUM_CH-1:0] envmode;
  logic [15:0]       env_per;
  logic              shape_cont;
  logic              shape_alt;
  logic              shape_hold;

  logic [DIV_W-1:0]  pre;
  logic              tick;

  logic [TONE_W-1:0] tcnt [NUM_CH];
  logic [NUM_CH-1:0] tone_bit;

  logic [4:0]        ncnt;
  logic [4:0]        nlim;
  logic [16:0]       lfsr;

  logic [15:0]       ecnt;
  logic [15:0]       elim;
  logic              env_step;
  logic [3:0]        pos;
  logic              dir_up;
  logic              hold;

  logic [NUM_CH-1:0] gate;
  logic [SUM_W-1:0]  lvl_sum;
  logic [OUT_W-1:0]  mix_next;

  // Counters wrap when count >= max(P,1)-1, so a zero period acts like one.
  function automatic logic [TONE_W-1:0] tone_lim(input logic [TONE_W-1:0] p);
    return (p == '0) ? '0 : p - TONE_W'(1);
  endfunction

  assign wr_stb   = in_wr & ~wr_prev;
  assign shape_wr = wr_stb && (in_reg == ADDR_W'(A_SHAPE));

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) wr_prev <= 1'b0;
    else        wr_prev <= in_wr;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        amp[i]    <= '0;
      end
      envmode    <= '0;
      noise_per  <= '0;
      tdis       <= '1;
      ndis       <= '1;
      env_per    <= '0;
      shape_cont <= 1'b0;
      shape_alt  <= 1'b0;
      shape_hold <= 1'b0;
    end else if (wr_stb) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_reg == ADDR_W'(2 * i))
          period[i][7:0] <= in_val;
        if (in_reg == ADDR_W'(2 * i + 1))
          period[i][TONE_W-1:8] <= in_val[TONE_W-9:0];
        if (in_reg == ADDR_W'(A_AMP + i)) begin
          amp[i]     <= in_val[3:0];
          envmode[i] <= in_val[4];
        end
      end
      if (in_reg == ADDR_W'(A_NP))   noise_per     <= in_val[4:0];
      if (in_reg == ADDR_W'(A_TDIS)) tdis          <= in_val[NUM_CH-1:0];
      if (in_reg == ADDR_W'(A_NDIS)) ndis          <= in_val[NUM_CH-1:0];
      if (in_reg == ADDR_W'(A_EPL))  env_per[7:0]  <= in_val;
      if (in_reg == ADDR_W'(A_EPH))  env_per[15:8] <= in_val;
      if (shape_wr) begin
        shape_cont <= in_val[3];
        shape_alt  <= in_val[1];
        shape_hold <= in_val[0];
      end
    end
  end

  assign tick = (pre == '0);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) pre <= '0;
    else        pre <= pre + DIV_W'(1);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_CH; i++) tcnt[i] <= '0;
      tone_bit <= '0;
    end else if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (tcnt[i] >= tone_lim(period[i])) begin
          tcnt[i]     <= '0;
          tone_bit[i] <= ~tone_bit[i];
        end else begin
          tcnt[i] <= tcnt[i] + TONE_W'(1);
        end
      end
    end
  end

  assign nlim = (noise_per == '0) ? 5'd0 : noise_per - 5'd1;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ncnt <= '0;
      lfsr <= 17'h00001;
    end else if (tick) begin
      if (ncnt >= nlim) begin
        ncnt <= '0;
        lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        ncnt <= ncnt + 5'd1;
      end
    end
  end

  assign elim     = (env_per == '0) ? 16'd0 : env_per - 16'd1;
  assign env_step = tick && (ecnt >= elim);

  // A shape write restarts the envelope and takes priority over a same-cycle step.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ecnt   <= '0;
      pos    <= 4'd15;
      dir_up <= 1'b0;
      hold   <= 1'b1;
    end else if (shape_wr) begin
      ecnt   <= '0;
      pos    <= 4'd0;
      dir_up <= in_val[2];
      hold   <= 1'b0;
    end else if (env_step) begin
      ecnt <= '0;
      if (!hold) begin
        if (pos != 4'd15) begin
          pos <= pos + 4'd1;
        end else if (!shape_cont) begin
          dir_up <= 1'b0;
          hold   <= 1'b1;
        end else if (shape_hold) begin
          dir_up <= dir_up ^ shape_alt;
          hold   <= 1'b1;
        end else begin
          pos    <= 4'd0;
          dir_up <= dir_up ^ shape_alt;
        end
      end
    end else if (tick) begin
      ecnt <= ecnt + 16'd1;
    end
  end

  assign out_env = dir_up ? pos : (4'd15 - pos);

  // A channel with both tone and noise disabled is gated permanently on.
  assign gate = (tone_bit | tdis) & ({NUM_CH{lfsr[0]}} | ndis);

  always_comb begin
    lvl_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gate[i])
        lvl_sum = lvl_sum + SUM_W'(envmode[i] ? out_env : amp[i]);
    end
  end

  assign mix_next = OUT_W'(lvl_sum) * OUT_W'(SCALE);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) out_mix <= '0;
    else        out_mix <= mix_next;
  end

endmodule

// File: tb/tb_psg_n.sv
// tb_psg_n: directed scoreboard bench for psg_n; stimulus queues expected samples
// tagged with a cycle number, and a negedge monitor pops and compares them.
module tb_psg_n;

  localparam int NUM_CH = 3;
  localparam int TONE_W = 12;
  localparam int DIV_W  = 4;
  localparam int ADDR_W = 5;
  localparam int OUT_W  = 16;

  localparam logic [4:0] A_P0L   = 5'd0;
  localparam logic [4:0] A_P1L   = 5'd2;
  localparam logic [4:0] A_NP    = 5'd6;
  localparam logic [4:0] A_TDIS  = 5'd7;
  localparam logic [4:0] A_NDIS  = 5'd8;
  localparam logic [4:0] A_AMP0  = 5'd9;
  localparam logic [4:0] A_AMP1  = 5'd10;
  localparam logic [4:0] A_AMP2  = 5'd11;
  localparam logic [4:0] A_EPL   = 5'd12;
  localparam logic [4:0] A_SHAPE = 5'd14;
  localparam int         LSB_MIX = 1456;

  typedef struct {
    int              cyc;
    logic [15:0]     mix;
    logic [3:0]      env;
    bit              cm;
    bit              ce;
    logic [8*12-1:0] tag;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic [4:0]  in_reg = '0;
  logic [7:0]  in_val = '0;
  logic        in_wr  = 1'b0;
  logic [15:0] out_mix;
  logic [3:0]  out_env;

  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  psg_n #(
    .NUM_CH(NUM_CH), .TONE_W(TONE_W), .DIV_W(DIV_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
  ) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_reg (in_reg),
    .in_val (in_val),
    .in_wr  (in_wr),
    .out_mix(out_mix),
    .out_env(out_env)
  );

  always #5 in_clk = ~in_clk;

  // Cycle n means "state after the n-th rising edge since reset release".
  always @(posedge in_clk or posedge in_rst) begin
    if (in_rst) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_output(input exp_t e);
    if (e.cm) begin
      n_checks++;
      if (out_mix !== e.mix) begin
        n_fail++;
        $display("[TB] FAIL %0s cyc=%0d out_mix got %0d expected %0d", e.tag, e.cyc, out_mix, e.mix);
      end
    end
    if (e.ce) begin
      n_checks++;
      if (out_env !== e.env) begin
        n_fail++;
        $display("[TB] FAIL %0s cyc=%0d out_env got %0d expected %0d", e.tag, e.cyc, out_env, e.env);
      end
    end
  endtask

  always @(negedge in_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      check_output(mon_e);
    end
  end

  task automatic expect_at(input int c, input int mix, input int env,
                           input bit cm, input bit ce, input logic [8*12-1:0] tag);
    exp_t e;
    e.cyc = c;
    e.mix = 16'(mix);
    e.env = 4'(env);
    e.cm  = cm;
    e.ce  = ce;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [4:0] addr, input logic [7:0] val);
    in_reg = addr;
    in_val = val;
    in_wr  = 1'b1;
    @(negedge in_clk);
    in_wr  = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc < n && g < 100000) begin
      @(negedge in_clk);
      g++;
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() > 0 && g < 100000) begin
      @(negedge in_clk);
      g++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    in_wr  = 1'b0;
    in_reg = '0;
    in_val = '0;
    in_rst = 1'b1;
    #1;
    expect_at(0, 0, 0, 1'b1, 1'b1, "reset");
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b0;
  endtask

  function automatic int env_exp(input logic [7:0] shape, input int k);
    int m;
    m = k % 32;
    case (shape)
      8'h0D:   return (k < 15) ? k : 15;
      8'h0A:   return (m < 16) ? 15 - m : m - 16;
      8'h00:   return (k < 15) ? 15 - k : 0;
      default: return (k <= 15) ? k : 0;
    endcase
  endfunction

  task automatic test_tone_p2();
    do_reset();
    expect_at(6,  21840, 0, 1'b1, 1'b0, "tone_p2");
    expect_at(33, 21840, 0, 1'b1, 1'b0, "tone_p2");
    expect_at(34, 0,     0, 1'b1, 1'b0, "tone_p2");
    expect_at(65, 0,     0, 1'b1, 1'b0, "tone_p2");
    expect_at(66, 21840, 0, 1'b1, 1'b0, "tone_p2");
    expect_at(97, 21840, 0, 1'b1, 1'b0, "tone_p2");
    expect_at(98, 0,     0, 1'b1, 1'b0, "tone_p2");
    apply_stimulus(A_P0L, 8'd2);
    apply_stimulus(A_AMP0, 8'h0F);
    apply_stimulus(A_TDIS, 8'hFE);
    wait_cyc(100);
  endtask

  task automatic test_all_ch();
    do_reset();
    expect_at(4,  43680, 0, 1'b1, 1'b0, "all_ch");
    expect_at(6,  65520, 0, 1'b1, 1'b0, "all_ch");
    expect_at(40, 65520, 0, 1'b1, 1'b0, "all_ch");
    apply_stimulus(A_AMP0, 8'h0F);
    apply_stimulus(A_AMP1, 8'h0F);
    apply_stimulus(A_AMP2, 8'h0F);
    wait_cyc(41);
    // Assert reset just after a rising edge; the next falling edge must already see zero.
    @(posedge in_clk);
    #1;
    in_rst = 1'b1;
    #1;
    expect_at(0, 0, 0, 1'b1, 1'b1, "async_rst");
    @(negedge in_clk);
    @(negedge in_clk);
  endtask

  task automatic test_p0();
    do_reset();
    expect_at(5,  21840, 0, 1'b1, 1'b0, "p0_ch1");
    expect_at(17, 21840, 0, 1'b1, 1'b0, "p0_ch1");
    expect_at(18, 0,     0, 1'b1, 1'b0, "p0_ch1");
    expect_at(33, 0,     0, 1'b1, 1'b0, "p0_ch1");
    expect_at(34, 21840, 0, 1'b1, 1'b0, "p0_ch1");
    expect_at(49, 21840, 0, 1'b1, 1'b0, "p1_ch1");
    expect_at(50, 0,     0, 1'b1, 1'b0, "p1_ch1");
    expect_at(65, 0,     0, 1'b1, 1'b0, "p1_ch1");
    expect_at(66, 21840, 0, 1'b1, 1'b0, "p1_ch1");
    apply_stimulus(A_AMP1, 8'h0F);
    apply_stimulus(A_TDIS, 8'hFD);
    apply_stimulus(A_P1L, 8'd1);
    wait_cyc(68);
  endtask

  task automatic test_shrink();
    do_reset();
    expect_at(800, 21840, 0, 1'b1, 1'b0, "shrink");
    expect_at(817, 21840, 0, 1'b1, 1'b0, "shrink");
    expect_at(818, 0,     0, 1'b1, 1'b0, "shrink");
    expect_at(865, 0,     0, 1'b1, 1'b0, "shrink");
    expect_at(866, 21840, 0, 1'b1, 1'b0, "shrink");
    apply_stimulus(A_P0L, 8'd100);
    apply_stimulus(A_AMP0, 8'h0F);
    apply_stimulus(A_TDIS, 8'hFE);
    wait_cyc(802);
    apply_stimulus(A_P0L, 8'd3);
    wait_cyc(868);
  endtask

  task automatic env_run(input logic [7:0] shape, input int nsteps);
    int lvl;
    do_reset();
    for (int k = 0; k <= nsteps; k++) begin
      lvl = env_exp(shape, k);
      expect_at(9 + 16 * k, LSB_MIX * lvl, lvl, 1'b1, 1'b1, "env_shape");
    end
    apply_stimulus(A_EPL, 8'd1);
    apply_stimulus(A_AMP0, 8'h10);
    apply_stimulus(A_SHAPE, shape);
    wait_cyc(9 + 16 * nsteps + 2);
  endtask

  task automatic test_wr_hold();
    do_reset();
    expect_at(9,  0, 0, 1'b0, 1'b1, "wr_hold");
    expect_at(25, 0, 1, 1'b0, 1'b1, "wr_hold");
    expect_at(41, 0, 2, 1'b0, 1'b1, "wr_hold");
    expect_at(57, 0, 3, 1'b0, 1'b1, "wr_hold");
    apply_stimulus(A_EPL, 8'd1);
    in_reg = A_SHAPE;
    in_val = 8'h0D;
    in_wr  = 1'b1;
    wait_cyc(42);
    in_wr  = 1'b0;
    wait_cyc(59);
  endtask

  task automatic test_coincide();
    do_reset();
    expect_at(40, 0, 2,  1'b0, 1'b1, "coincide");
    expect_at(50, 0, 15, 1'b0, 1'b1, "coincide");
    expect_at(64, 0, 15, 1'b0, 1'b1, "coincide");
    expect_at(65, 0, 14, 1'b0, 1'b1, "coincide");
    expect_at(81, 0, 13, 1'b0, 1'b1, "coincide");
    apply_stimulus(A_EPL, 8'd1);
    apply_stimulus(A_SHAPE, 8'h0D);
    wait_cyc(48);
    apply_stimulus(A_SHAPE, 8'h00);
    wait_cyc(83);
  endtask

  task automatic test_noise();
    logic [16:0] m;
    do_reset();
    m = 17'h00001;
    for (int k = 1; k <= 1000; k++) begin
      m = {m[0] ^ m[3], m[16:1]};
      expect_at(10 + 16 * (k - 1), m[0] ? 21840 : 0, 0, 1'b1, 1'b0, "noise");
    end
    apply_stimulus(A_AMP0, 8'h0F);
    apply_stimulus(A_NDIS, 8'hFE);
    apply_stimulus(A_NP, 8'd1);
    wait_cyc(10 + 16 * 999 + 2);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cyc=%0d required finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] psg_n directed scoreboard run");
    test_tone_p2();
    test_all_ch();
    test_p0();
    test_shrink();
    env_run(8'h0D, 20);
    env_run(8'h0A, 40);
    env_run(8'h00, 20);
    env_run(8'h04, 20);
    test_wr_hold();
    test_coincide();
    test_noise();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
